// File: rtl/share_enc_pkg.sv
// Shared constants and types for the 2-share masking front-end.
package share_enc_pkg;

    localparam int unsigned LFSR_W = 32;

    // Feedback taps {31, 21, 1, 0}
    localparam int unsigned TAP_3 = 31;
    localparam int unsigned TAP_2 = 21;
    localparam int unsigned TAP_1 = 1;
    localparam int unsigned TAP_0 = 0;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'hACE1_2024;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } enc_state_e;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return s[TAP_3] ^ s[TAP_2] ^ s[TAP_1] ^ s[TAP_0];
    endfunction

endpackage

// File: rtl/lfsr_leap.sv
// Leap-ahead Fibonacci LFSR: performs R single steps combinationally and
// returns the per-step feedback bits together with the advanced state.
module lfsr_leap
    import share_enc_pkg::*;
#(
    parameter int unsigned R = 12
) (
    input  logic [LFSR_W-1:0] s,
    output logic [LFSR_W-1:0] s_next,
    output logic [R-1:0]      r
);

    logic [LFSR_W-1:0] walk;
    logic              fb;

    always_comb begin
        walk = s;
        fb   = 1'b0;
        r    = '0;
        for (int k = 0; k < R; k++) begin
            fb   = lfsr_fb(walk);
            r[k] = fb;
            walk = {walk[LFSR_W-2:0], fb};
        end
        s_next = walk;
    end

endmodule

// File: rtl/share_encoder.sv
// Splits plaintext operand pairs into Boolean shares plus carry-refresh randomness.
// Optional runtime reseed port is enabled by defining SHARE_ENC_RESEED_EN.
module share_encoder
    import share_enc_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned WARMUP = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  a0,
    output logic [WIDTH-1:0]  a1,
    output logic [WIDTH-1:0]  b0,
    output logic [WIDTH-1:0]  b1,
    output logic [WIDTH-1:0]  rn
`ifdef SHARE_ENC_RESEED_EN
    ,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed
`endif
);

    localparam int unsigned R     = 3 * WIDTH;
    localparam int unsigned CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP - 1);

    enc_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [LFSR_W-1:0] s_q;
    logic [LFSR_W-1:0] s_next;
    logic [R-1:0]      r;
    logic              accept;
    logic              reseed;

    lfsr_leap #(
        .R (R)
    ) u_lfsr_leap (
        .s      (s_q),
        .s_next (s_next),
        .r      (r)
    );

`ifdef SHARE_ENC_RESEED_EN
    assign reseed = seed_valid;
`else
    assign reseed = 1'b0;
`endif

    // A reseed request blocks acceptance in the same cycle.
    always_comb begin
        in_ready = (state_q == RUN) && (!out_valid || out_ready) && !reseed;
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WARM;
            cnt_q     <= '0;
            s_q       <= DEFAULT_SEED;
            out_valid <= 1'b0;
            a0        <= '0;
            a1        <= '0;
            b0        <= '0;
            b1        <= '0;
            rn        <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                a0        <= a ^ r[WIDTH-1:0];
                a1        <= r[WIDTH-1:0];
                b0        <= b ^ r[2*WIDTH-1:WIDTH];
                b1        <= r[2*WIDTH-1:WIDTH];
                rn        <= r[R-1:2*WIDTH];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

`ifdef SHARE_ENC_RESEED_EN
            if (seed_valid) begin
                s_q     <= (seed == '0) ? DEFAULT_SEED : seed;
                state_q <= WARM;
                cnt_q   <= '0;
            end else
`endif
            begin
                // The LFSR moves only on warm-up cycles and accepted transfers.
                case (state_q)
                    WARM: begin
                        s_q <= s_next;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= RUN;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            s_q <= s_next;
                        end
                    end
                    default: begin
                        state_q <= WARM;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_share_encoder.sv
// Directed self-checking bench for share_encoder against a bit-serial LFSR model.
module tb_share_encoder;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic [W-1:0] b0;
    logic [W-1:0] b1;
    logic [W-1:0] rn;
`ifdef SHARE_ENC_RESEED_EN
    logic         seed_valid;
    logic [31:0]  seed;
`endif

    share_encoder #(
        .WIDTH  (W),
        .WARMUP (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .a0         (a0),
        .a1         (a1),
        .b0         (b0),
        .b1         (b1),
        .rn         (rn)
`ifdef SHARE_ENC_RESEED_EN
        ,
        .seed_valid (seed_valid),
        .seed       (seed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]  m_s;
    logic [W-1:0] e_a, e_b, e_ma, e_mb, e_rr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One leap of 3*W serial steps; r[k] is the feedback of step k.
    task automatic model_advance(output logic [3*W-1:0] r);
        logic fb;
        r = '0;
        for (int k = 0; k < 3 * W; k++) begin
            fb   = m_s[31] ^ m_s[21] ^ m_s[1] ^ m_s[0];
            r[k] = fb;
            m_s  = {m_s[30:0], fb};
        end
    endtask

    // Record the shares expected for an accept of (pa, pb) happening at the next edge.
    task automatic expect_accept(input logic [W-1:0] pa, input logic [W-1:0] pb);
        logic [3*W-1:0] r;
        model_advance(r);
        e_a  = pa;
        e_b  = pb;
        e_ma = r[W-1:0];
        e_mb = r[2*W-1:W];
        e_rr = r[3*W-1:2*W];
    endtask

    task automatic check_out(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".a_recomb"},  32'(a0 ^ a1),   32'(e_a));
        check({tag, ".b_recomb"},  32'(b0 ^ b1),   32'(e_b));
        check({tag, ".a1"},        32'(a1),        32'(e_ma));
        check({tag, ".b1"},        32'(b1),        32'(e_mb));
        check({tag, ".rn"},        32'(rn),        32'(e_rr));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".outs"},      32'({a0, a1, b0, b1, rn}), 32'd0);
    endtask

    // Release reset and walk through warm-up, checking in_ready each cycle.
    task automatic warmup_seq(input string tag);
        logic [3*W-1:0] r;
        for (int k = 0; k < 16; k++) begin
            #1;
            check({tag, ".in_ready_low"}, 32'(in_ready), 32'd0);
            model_advance(r);
            @(negedge clk);
        end
        #1;
        check({tag, ".in_ready_rise"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 4'b1010;
        b         = 4'b0110;
`ifdef SHARE_ENC_RESEED_EN
        seed_valid = 1'b0;
        seed       = '0;
`endif
        repeat (3) @(negedge clk);
        check_zero("reset");
        check("reset.in_ready", 32'(in_ready), 32'd0);

        // Warm-up with in_valid held high; nothing may be accepted.
        m_s = 32'hACE1_2024;
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [3*W-1:0] r;
            #1;
            check("warm.in_ready", 32'(in_ready), 32'd0);
            check("warm.out_valid", 32'(out_valid), 32'd0);
            model_advance(r);
            @(negedge clk);
        end
        #1;
        check("warm.in_ready_rise", 32'(in_ready), 32'd1);
        check_zero("warm.pre_accept");

        // Single transfer a=1010, b=0110.
        expect_accept(4'b1010, 4'b0110);
        @(negedge clk);
        in_valid = 1'b0;
        check_out("single");
        check("single.a0", 32'(a0), 32'(4'b1010 ^ e_ma));

        // Backpressure: out_ready low for 5 cycles with a new operand waiting.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 4'b0011;
        b         = 4'b1100;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp.in_ready", 32'(in_ready), 32'd0);
            check_out("bp.stable");
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(in_ready), 32'd1);
        expect_accept(4'b0011, 4'b1100);
        @(negedge clk);
        check_out("bp.resume");

        // Streaming: 100 back-to-back transfers.
        for (int i = 0; i < 100; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            #1;
            check("stream.in_ready", 32'(in_ready), 32'd1);
            expect_accept(a, b);
            @(negedge clk);
            check_out("stream");
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("drain.out_valid", 32'(out_valid), 32'd0);

        // Async reset in the middle of a stream.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = W'(i + 5);
            b = W'(i + 9);
            expect_accept(a, b);
            @(negedge clk);
            check_out("pre_rst");
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        check("async_rst.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        m_s   = 32'hACE1_2024;
        a     = 4'b1111;
        b     = 4'b0001;
        rst_n = 1'b1;
        warmup_seq("rewarm");
        expect_accept(4'b1111, 4'b0001);
        @(negedge clk);
        in_valid = 1'b0;
        check_out("rewarm.first");

`ifdef SHARE_ENC_RESEED_EN
        // Reseed with zero while a result is pending downstream.
        out_ready  = 1'b0;
        seed_valid = 1'b1;
        seed       = 32'h0;
        in_valid   = 1'b1;
        #1;
        check("reseed.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        seed_valid = 1'b0;
        m_s        = 32'hACE1_2024;
        check_out("reseed.pending");
        out_ready = 1'b1;
        a         = 4'b0101;
        b         = 4'b1001;
        warmup_seq("reseed_warm");
        expect_accept(4'b0101, 4'b1001);
        @(negedge clk);
        in_valid = 1'b0;
        check_out("reseed.first");
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected end before 200000");
        $fatal(1);
    end

endmodule
